// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller driving an external 1-bit full adder
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_x,
  output logic             fa_y,
  output logic             fa_z,
  input  logic             fa_s,
  input  logic             fa_c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter must hold 0..WIDTH-1 and be at least one bit wide.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // Partial-sum register keeps only the bits already produced; the newest bit comes straight from fa_s.
  localparam int SW = (WIDTH > 1) ? WIDTH - 1 : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [SW-1:0]    s_sh, s_sh_next;
  logic [WIDTH-1:0] s_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last;

  assign last = (cnt == CW'(WIDTH - 1));

  generate
    if (WIDTH == 1) begin : g_w1
      assign s_next    = fa_s;
      assign s_sh_next = s_sh;
    end else begin : g_wn
      assign s_next    = {fa_s, s_sh};
      assign s_sh_next = s_next[WIDTH-1:1];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic and state-decoded outputs, including the full-adder operand bits.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    fa_x       = 1'b0;
    fa_y       = 1'b0;
    fa_z       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        fa_x = a_sh[0];
        fa_y = b_sh[0];
        fa_z = carry;
        if (last) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand/partial-sum shifting, carry chain, bit counter and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            s_sh  <= '0;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          s_sh  <= s_sh_next;
          carry <= fa_c;
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum  <= s_next;
            cout <= fa_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, meaning operand width in bits (legal range 1..32).
REQ-002 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to begin an addition.
REQ-005 SHALL have port a, input, WIDTH, operand A (unsigned).
REQ-006 SHALL have port b, input, WIDTH, operand B (unsigned).
REQ-007 SHALL have port cin, input, 1, carry-in for the LSB.
REQ-008 SHALL have port fa_x, output, 1, full-adder operand bit x.
REQ-009 SHALL have port fa_y, output, 1, full-adder operand bit y.
REQ-010 SHALL have port fa_z, output, 1, full-adder carry-in bit z.
REQ-011 SHALL have port fa_s, input, 1, sum bit returned by the external 1-bit full adder (combinational).
REQ-012 SHALL have port fa_c, input, 1, carry bit returned by the external full adder.
REQ-013 SHALL have port busy, output, 1, high in RUN and DONE states.
REQ-014 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-015 SHALL have port sum, output, WIDTH, registered result.
REQ-016 SHALL have port cout, output, 1, registered carry out of the MSB.

Function
REQ-017 SHALL implement an FSM with three states: IDLE, RUN, DONE.
REQ-018 In IDLE, start=1 at a clock edge SHALL accept the request: latch a and b into shift registers, load the carry register from cin, clear the bit counter, and go to RUN.
REQ-019 start SHALL be ignored in RUN and DONE; the latched operands SHALL NOT change until the next accepted start.
REQ-020 In RUN, fa_x SHALL be A-shift[0], fa_y SHALL be B-shift[0], and fa_z SHALL be the carry register, all driven combinationally from state.
REQ-021 On each RUN edge, the block SHALL shift fa_s into the MSB of the sum shift register (LSB-first assembly), load fa_c into the carry register, shift A and B right by one, and increment the counter.
REQ-022 RUN SHALL last exactly WIDTH cycles; on the edge where counter==WIDTH-1, the block SHALL load sum from the completed shift value (including this cycle's fa_s), load cout from fa_c, and go to DONE.
REQ-023 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-024 Latency: start sampled at edge k gives done=1 in cycle k+WIDTH+1; back-to-back throughput is one addition per WIDTH+2 cycles.
REQ-025 In IDLE and DONE, fa_x, fa_y and fa_z SHALL be 0.
REQ-026 sum and cout SHALL change only at the RUN→DONE transition or at reset, and SHALL hold their value through IDLE and through the whole of the next operation.
REQ-027 Result SHALL equal (a + b + cin) mod 2^WIDTH, with cout = bit WIDTH of the full sum.
REQ-028 With WIDTH=1, RUN SHALL last one cycle; the counter SHALL be at least 1 bit wide.

Reset
REQ-029 While rst=1 at an edge, the block SHALL enter IDLE and clear busy, done, sum, cout, the carry register, the counter and the shift registers; rst SHALL take priority over start.
REQ-030 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse, and sum and cout SHALL read 0 afterwards.

Verification (WIDTH=8, external 1-bit full adder on fa_*)
REQ-031 rst high 2 cycles -> busy=0, done=0, sum=0x00, cout=0, fa_x/y/z=0.
REQ-032 a=0x5A, b=0x33, cin=0, start pulsed at edge k -> busy from k+1, done=1 only in cycle k+9, sum=0x8D, cout=0.
REQ-033 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-034 start held high continuously, with a/b changed during RUN -> the second request is accepted only in the IDLE cycle after DONE; the first result matches the originally latched operands.
REQ-035 rst pulsed in the 4th RUN cycle -> IDLE on the next cycle, no done pulse, sum=0x00, cout=0; a following start then completes correctly.
REQ-036 Bench SHALL check fa_x/fa_y/fa_z each RUN cycle against the expected operand bits and running carry, LSB first.
